ultrasonic_scan_scheduler: RTL and testbench

Time-shares the vehicle's ultrasonic range sensors on the PMOD headers so only one sensor fires at a time, which avoids acoustic crosstalk. For each enabled sensor in round-robin order it issues a trigger pulse, times the echo pulse in microseconds and stores the result per sensor. The stored results are read back by the PS through the GPIO word path, and the enable mask is written by the PS. The block sits in the PS clock domain, between the PS GPIO registers and the PMOD ja..je pins.

---
 rtl/ultrasonic_pkg.sv | 41 ++++
 rtl/ultrasonic_tick_gen.sv | 28 ++
 rtl/ultrasonic_scan_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_ultrasonic_scan_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared FSM state type, result saturation constant and round-robin search
// for the ultrasonic scan scheduler.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_STORE,
      S_GUARD
   } state_t;

   // Sliced down to RES_W by the user; RES_W may be at most 32.
   localparam logic [31:0] RES_SAT = 32'hFFFF_FFFF;

   localparam int MAX_SENSORS = 8;

   // Lowest enabled index above cur, wrapping; from_start makes the search begin at 0.
   function automatic logic [2:0] rr_next(input logic [7:0] mask,
                                          input logic [2:0] cur,
                                          input int         n,
                                          input logic       from_start);
      logic [2:0] pick;
      logic       found;
      int         base;
      int         idx;
      pick  = cur;
      found = 1'b0;
      base  = from_start ? n - 1 : int'(cur);
      for (int k = 1; k <= MAX_SENSORS; k++) begin
         idx = (base + k) % n;
         if (!found && k <= n && mask[idx[2:0]]) begin
            pick  = idx[2:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/ultrasonic_tick_gen.sv
// 1 us tick prescaler; restart forces the count back to zero so that each
// FSM interval begins on a fresh microsecond boundary.
module ultrasonic_tick_gen
#(
   parameter int CLK_FREQ_MHZ = 100
) (
   input  logic clk,
   input  logic ps_nrst,
   input  logic restart,
   output logic tick
);

   localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_FREQ_MHZ - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!ps_nrst || restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin ultrasonic ranging: triggers one sensor at a time, times its echo
// in microseconds and keeps a per-sensor result. Define ULTRASONIC_AVG_EN to
// store a two-sample running average instead of the raw sample.
module ultrasonic_scan_scheduler
   import ultrasonic_pkg::*;
#(
   parameter int N_SENSORS    = 4,
   parameter int CLK_FREQ_MHZ = 100,
   parameter int TRIG_US      = 10,
   parameter int TIMEOUT_US   = 30000,
   parameter int GUARD_US     = 10000,
   parameter int RES_W        = 16
) (
   input  logic                         clk,
   input  logic                         ps_nrst,
   input  logic [N_SENSORS-1:0]         enable_mask,
   input  logic [N_SENSORS-1:0]         echo,
   output logic [N_SENSORS-1:0]         trig,
   input  logic [$clog2(N_SENSORS)-1:0] rd_sel,
   output logic [RES_W-1:0]             rd_data,
   output logic                         rd_timeout,
   output logic                         rd_valid,
   output logic [$clog2(N_SENSORS)-1:0] cur_sensor,
   output logic                         busy,
   output logic                         cycle_done
);

   localparam int SEL_W = $clog2(N_SENSORS);
   localparam int CNT_W = RES_W + 1;
   localparam logic [RES_W-1:0] RES_MAX      = RES_SAT[RES_W-1:0];
   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_US - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_US - 1);

   state_t               state;
   state_t               state_nxt;
   logic [N_SENSORS-1:0] echo_s1;
   logic [N_SENSORS-1:0] echo_s2;
   logic [N_SENSORS-1:0] echo_s3;
   logic                 tick;
   logic                 restart;
   logic [CNT_W-1:0]     us_cnt;
   logic [SEL_W-1:0]     rr_pick;
   logic [SEL_W-1:0]     trig_sel;
   logic                 has_run;
   logic                 echo_rise;
   logic                 echo_fall;
   logic                 mask_cur;
   logic                 timed_out;
   logic [CNT_W-1:0]     meas_val;
   logic                 meas_to;
   logic [RES_W-1:0]     raw_val;
   logic [RES_W-1:0]     store_val;
   logic [RES_W-1:0]     res_mem [N_SENSORS];
   logic [N_SENSORS-1:0] to_mem;
   logic [N_SENSORS-1:0] valid_mem;
`ifdef ULTRASONIC_AVG_EN
   logic [RES_W:0]       avg_sum;
`endif

   ultrasonic_tick_gen #(
      .CLK_FREQ_MHZ (CLK_FREQ_MHZ)
   ) u_tick (
      .clk     (clk),
      .ps_nrst (ps_nrst),
      .restart (restart),
      .tick    (tick)
   );

   // Two-flop synchroniser plus one delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (!ps_nrst) begin
         echo_s1 <= '0;
         echo_s2 <= '0;
         echo_s3 <= '0;
      end else begin
         echo_s1 <= echo;
         echo_s2 <= echo_s1;
         echo_s3 <= echo_s2;
      end
   end

   assign echo_rise = echo_s2[cur_sensor] & ~echo_s3[cur_sensor];
   assign echo_fall = ~echo_s2[cur_sensor] & echo_s3[cur_sensor];
   assign mask_cur  = enable_mask[cur_sensor];
   assign timed_out = tick && (us_cnt == TIMEOUT_LAST);
   assign rr_pick   = SEL_W'(rr_next(8'(enable_mask), 3'(cur_sensor), N_SENSORS, !has_run));
   assign trig_sel  = (state == S_IDLE) ? rr_pick : cur_sensor;
   assign restart   = (state_nxt != state);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!ps_nrst || restart) begin
         us_cnt <= '0;
      end else if (tick && us_cnt != '1) begin
         us_cnt <= us_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt  = state;
      cycle_done = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (enable_mask != '0) begin
               state_nxt  = S_TRIG;
               cycle_done = ps_nrst && (rr_pick <= cur_sensor);
            end
         end
         S_TRIG: begin
            if (!mask_cur)                           state_nxt = S_GUARD;
            else if (tick && us_cnt == TRIG_LAST)    state_nxt = S_WAIT_RISE;
         end
         S_WAIT_RISE: begin
            if (!mask_cur)                           state_nxt = S_GUARD;
            else if (echo_rise)                      state_nxt = S_MEASURE;
            else if (timed_out)                      state_nxt = S_STORE;
         end
         S_MEASURE: begin
            if (!mask_cur)                           state_nxt = S_GUARD;
            else if (echo_fall || timed_out)         state_nxt = S_STORE;
         end
         S_STORE: begin
            state_nxt = S_GUARD;
         end
         S_GUARD: begin
            if (tick && us_cnt == GUARD_LAST)        state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // trig is registered from the next state so it rises and falls on state-change edges.
   always_ff @(posedge clk) begin
      if (!ps_nrst) begin
         state      <= S_IDLE;
         cur_sensor <= '0;
         has_run    <= 1'b0;
         trig       <= '0;
         meas_val   <= '0;
         meas_to    <= 1'b0;
      end else begin
         state <= state_nxt;
         trig  <= (state_nxt == S_TRIG) ? (N_SENSORS'(1) << trig_sel) : '0;
         if (state == S_IDLE && state_nxt == S_TRIG) begin
            cur_sensor <= rr_pick;
            has_run    <= 1'b1;
         end
         if (state == S_WAIT_RISE && state_nxt == S_STORE) begin
            meas_val <= '0;
            meas_to  <= 1'b1;
         end
         if (state == S_MEASURE && state_nxt == S_STORE) begin
            meas_val <= us_cnt;
            meas_to  <= ~echo_fall;
         end
      end
   end

   always_comb begin
      raw_val   = (meas_val > {1'b0, RES_MAX}) ? RES_MAX : meas_val[RES_W-1:0];
      store_val = raw_val;
`ifdef ULTRASONIC_AVG_EN
      avg_sum = {1'b0, res_mem[cur_sensor]} + {1'b0, raw_val};
      if (valid_mem[cur_sensor] && !to_mem[cur_sensor]) begin
         store_val = avg_sum[RES_W:1];
      end
`endif
      if (meas_to) begin
         store_val = RES_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (!ps_nrst) begin
         for (int i = 0; i < N_SENSORS; i++) begin
            res_mem[i] <= '0;
         end
         to_mem    <= '0;
         valid_mem <= '0;
      end else if (state == S_STORE) begin
         res_mem[cur_sensor]   <= store_val;
         to_mem[cur_sensor]    <= meas_to;
         valid_mem[cur_sensor] <= 1'b1;
      end
   end

   // Out-of-range indices (non power-of-two sensor counts) read as empty.
   always_ff @(posedge clk) begin
      if (!ps_nrst) begin
         rd_data    <= '0;
         rd_timeout <= 1'b0;
         rd_valid   <= 1'b0;
      end else if (int'(rd_sel) < N_SENSORS) begin
         rd_data    <= res_mem[rd_sel];
         rd_timeout <= to_mem[rd_sel];
         rd_valid   <= valid_mem[rd_sel];
      end else begin
         rd_data    <= '0;
         rd_timeout <= 1'b0;
         rd_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Directed bench for ultrasonic_scan_scheduler with a behavioural echo model
// per sensor; define ULTRASONIC_AVG_EN to also exercise the averaging path.
module tb_ultrasonic_scan_scheduler;

   localparam int N           = 4;
   localparam int CLKS_PER_US = 10;

   logic        clk         = 1'b0;
   logic        ps_nrst     = 1'b0;
   logic [3:0]  enable_mask = 4'b0000;
   logic [3:0]  echo_force  = 4'b0000;
   logic [3:0]  echo_model;
   logic [3:0]  model_busy;
   logic [3:0]  echo;
   logic [3:0]  trig;
   logic [1:0]  rd_sel      = 2'd0;
   logic [15:0] rd_data;
   logic        rd_timeout;
   logic        rd_valid;
   logic [1:0]  cur_sensor;
   logic        busy;
   logic        cycle_done;

   int          vectors     = 0;
   int          miscompares = 0;
   int          delay_us [4];
   int          width_us [4];
   logic [3:0]  model_on    = 4'b0000;
   int          cyc         = 0;
   int          cd_count    = 0;
   logic [3:0]  prev_trig   = 4'b0000;
   int          rise_cyc [4];
   logic        saw_trig2   = 1'b0;
   int          start_idx [$];
   int          start_cyc [$];
   int          width_q [$];

   assign echo = echo_model | echo_force;

   always #5 clk = ~clk;

   ultrasonic_scan_scheduler #(
      .N_SENSORS    (N),
      .CLK_FREQ_MHZ (CLKS_PER_US),
      .TRIG_US      (10),
      .TIMEOUT_US   (500),
      .GUARD_US     (50),
      .RES_W        (16)
   ) dut (
      .clk         (clk),
      .ps_nrst     (ps_nrst),
      .enable_mask (enable_mask),
      .echo        (echo),
      .trig        (trig),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .rd_timeout  (rd_timeout),
      .rd_valid    (rd_valid),
      .cur_sensor  (cur_sensor),
      .busy        (busy),
      .cycle_done  (cycle_done)
   );

   // Each sensor answers its own trigger fall with a delayed echo pulse.
   for (genvar g = 0; g < N; g++) begin : g_echo
      logic e   = 1'b0;
      logic act = 1'b0;
      assign echo_model[g] = e;
      assign model_busy[g] = act;
      initial forever begin
         @(negedge trig[g]);
         if (model_on[g]) begin
            act = 1'b1;
            repeat (delay_us[g] * CLKS_PER_US) @(posedge clk);
            #1 e = 1'b1;
            repeat (width_us[g] * CLKS_PER_US) @(posedge clk);
            #1 e = 1'b0;
            act = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (trig[i] && !prev_trig[i]) begin
            start_idx.push_back(i);
            start_cyc.push_back(cyc);
            rise_cyc[i] = cyc;
         end
         if (!trig[i] && prev_trig[i]) width_q.push_back(cyc - rise_cyc[i]);
      end
      if (trig[2]) saw_trig2 = 1'b1;
      if (cycle_done) cd_count++;
      prev_trig = trig;
   end

   initial begin
      #950000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   task automatic do_reset();
      @(posedge clk);
      #1 ps_nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start_idx.delete();
      start_cyc.delete();
      width_q.delete();
      cd_count  = 0;
      saw_trig2 = 1'b0;
      ps_nrst   = 1'b1;
   endtask

   task automatic wait_starts(input int n, input string tag);
      int budget = 30000;
      while (start_idx.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (start_idx.size() < n) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s_starts saw %0d trigger starts, want %0d", tag, start_idx.size(), n);
      end
   endtask

   task automatic quiesce();
      int budget = 20000;
      enable_mask = 4'b0000;
      model_on    = 4'b0000;
      echo_force  = 4'b0000;
      while ((busy || model_busy != 4'b0000) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (busy || model_busy != 4'b0000) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL quiesce busy=%b model_busy=%b, want 0", busy, model_busy);
      end
   endtask

   task automatic test_reset();
      ps_nrst     = 1'b0;
      enable_mask = 4'b1111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (trig !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_trig got %b want 0000", trig); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      vectors++;
      if (cycle_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cycle_done got %b want 0", cycle_done); end
      vectors++;
      if ({rd_valid, rd_timeout, rd_data, cur_sensor} !== 20'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_rd got valid=%b to=%b data=%h cur=%0d want all 0", rd_valid, rd_timeout, rd_data, cur_sensor);
      end
      enable_mask = 4'b0000;
      do_reset();
   endtask

   task automatic test_single_sensor();
      int w;
      do_reset();
      delay_us[0] = 100;
      width_us[0] = 250;
      model_on    = 4'b0001;
      rd_sel      = 2'd0;
      enable_mask = 4'b0001;
      wait_starts(3, "single");
      @(negedge clk);
      w = (width_q.size() > 0) ? width_q[0] : -1;
      vectors++;
      if (w != 100) begin miscompares++; $display("[TB] FAIL single_trig_width got %0d clk want 100", w); end
      vectors++;
      if (rd_data < 16'd249 || rd_data > 16'd251) begin miscompares++; $display("[TB] FAIL single_rd_data got %0d want 250+-1", rd_data); end
      vectors++;
      if (rd_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL single_rd_timeout got %b want 0", rd_timeout); end
      vectors++;
      if (rd_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_rd_valid got %b want 1", rd_valid); end
      vectors++;
      if (cd_count != 3) begin miscompares++; $display("[TB] FAIL single_cycle_done got %0d pulses want 3", cd_count); end
      quiesce();
   endtask

   task automatic test_round_robin();
      int exp_order [6] = '{0, 1, 3, 0, 1, 3};
      int got;
      int min_gap;
      do_reset();
      for (int i = 0; i < N; i++) begin
         delay_us[i] = 50;
         width_us[i] = 100;
      end
      model_on    = 4'b1011;
      enable_mask = 4'b1011;
      wait_starts(6, "rr");
      for (int i = 0; i < 6; i++) begin
         got = (start_idx.size() > i) ? start_idx[i] : -1;
         vectors++;
         if (got != exp_order[i]) begin miscompares++; $display("[TB] FAIL rr_order[%0d] got %0d want %0d", i, got, exp_order[i]); end
      end
      vectors++;
      if (saw_trig2 !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_trig2 got asserted want never"); end
      vectors++;
      if (cd_count != 2) begin miscompares++; $display("[TB] FAIL rr_cycle_done got %0d pulses want 2", cd_count); end
      min_gap = 1000000;
      for (int i = 1; i < start_cyc.size(); i++) begin
         if (start_cyc[i] - start_cyc[i-1] < min_gap) min_gap = start_cyc[i] - start_cyc[i-1];
      end
      vectors++;
      if (min_gap < 1500) begin miscompares++; $display("[TB] FAIL rr_spacing got %0d clk want >= 1500", min_gap); end
      quiesce();
   endtask

   task automatic test_no_echo();
      int gap;
      int nxt;
      do_reset();
      delay_us[0] = 50;
      width_us[0] = 100;
      model_on    = 4'b0001;
      enable_mask = 4'b0011;
      wait_starts(3, "noecho");
      gap = (start_cyc.size() > 2) ? start_cyc[2] - start_cyc[1] : -1;
      nxt = (start_idx.size() > 2) ? start_idx[2] : -1;
      vectors++;
      if (gap < 5600 || gap > 5604) begin miscompares++; $display("[TB] FAIL noecho_wait got %0d clk want 5602+-2", gap); end
      vectors++;
      if (nxt != 0) begin miscompares++; $display("[TB] FAIL noecho_next got sensor %0d want 0", nxt); end
      rd_sel = 2'd1;
      repeat (2) @(negedge clk);
      vectors++;
      if (rd_data !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL noecho_rd_data got %h want ffff", rd_data); end
      vectors++;
      if ({rd_timeout, rd_valid} !== 2'b11) begin miscompares++; $display("[TB] FAIL noecho_flags got to=%b valid=%b want 1 1", rd_timeout, rd_valid); end
      rd_sel = 2'd0;
      repeat (2) @(negedge clk);
      vectors++;
      if (rd_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL noecho_s0_timeout got %b want 0", rd_timeout); end
      quiesce();
   endtask

   task automatic test_echo_timeout();
      do_reset();
      delay_us[0] = 20;
      width_us[0] = 600;
      model_on    = 4'b0001;
      rd_sel      = 2'd0;
      enable_mask = 4'b0001;
      wait_starts(2, "longecho");
      repeat (2) @(negedge clk);
      vectors++;
      if ({rd_timeout, rd_data} !== {1'b1, 16'hFFFF}) begin
         miscompares++;
         $display("[TB] FAIL longecho_result got to=%b data=%h want 1 ffff", rd_timeout, rd_data);
      end
      quiesce();
      echo_force = 4'b0001;
      do_reset();
      enable_mask = 4'b0001;
      wait_starts(2, "stuck");
      repeat (2) @(negedge clk);
      vectors++;
      if ({rd_valid, rd_timeout, rd_data} !== {2'b11, 16'hFFFF}) begin
         miscompares++;
         $display("[TB] FAIL stuck_result got valid=%b to=%b data=%h want 1 1 ffff", rd_valid, rd_timeout, rd_data);
      end
      quiesce();
   endtask

   task automatic test_mask_clear();
      int n;
      int budget;
      do_reset();
      delay_us[0] = 50;
      width_us[0] = 100;
      model_on    = 4'b0001;
      rd_sel      = 2'd0;
      enable_mask = 4'b0001;
      wait_starts(2, "maskclr");
      width_us[0] = 400;
      budget = 1000;
      while (trig[0] && budget > 0) begin @(negedge clk); budget--; end
      repeat (1500) @(negedge clk);
      enable_mask = 4'b0000;
      @(negedge clk);
      vectors++;
      if (trig !== 4'b0000) begin miscompares++; $display("[TB] FAIL maskclr_trig got %b want 0000", trig); end
      n = 1;
      while (busy && n < 2000) begin @(negedge clk); n++; end
      vectors++;
      if (n < 499 || n > 503) begin miscompares++; $display("[TB] FAIL maskclr_guard got %0d clk to idle want 501+-2", n); end
      vectors++;
      if (rd_data < 16'd99 || rd_data > 16'd101 || rd_timeout !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL maskclr_keep got data=%0d to=%b want 100+-1 0", rd_data, rd_timeout);
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL maskclr_idle got busy=%b want 0", busy); end
      quiesce();
   endtask

   task automatic test_reset_mid_trig();
      do_reset();
      delay_us[0] = 20;
      width_us[0] = 50;
      model_on    = 4'b0001;
      rd_sel      = 2'd0;
      enable_mask = 4'b0001;
      wait_starts(2, "rstmid");
      repeat (30) @(negedge clk);
      vectors++;
      if ({trig[0], rd_valid} !== 2'b11) begin miscompares++; $display("[TB] FAIL rstmid_pre got trig0=%b valid=%b want 1 1", trig[0], rd_valid); end
      ps_nrst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({trig, busy, cycle_done} !== 6'd0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_outputs got trig=%b busy=%b cd=%b want 0", trig, busy, cycle_done);
      end
      enable_mask = 4'b0000;
      @(posedge clk);
      #1 ps_nrst = 1'b1;
      for (int s = 0; s < N; s++) begin
         rd_sel = 2'(s);
         repeat (2) @(negedge clk);
         vectors++;
         if ({rd_valid, rd_timeout, rd_data} !== 18'd0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_sensor%0d got valid=%b to=%b data=%h want 0", s, rd_valid, rd_timeout, rd_data);
         end
      end
      quiesce();
   endtask

`ifdef ULTRASONIC_AVG_EN
   task automatic test_average();
      do_reset();
      delay_us[0] = 20;
      width_us[0] = 200;
      model_on    = 4'b0001;
      rd_sel      = 2'd0;
      enable_mask = 4'b0001;
      wait_starts(2, "avg");
      width_us[0] = 300;
      @(negedge clk);
      vectors++;
      if (rd_data < 16'd199 || rd_data > 16'd201) begin miscompares++; $display("[TB] FAIL avg_first got %0d want 200+-1", rd_data); end
      wait_starts(3, "avg");
      @(negedge clk);
      vectors++;
      if (rd_data < 16'd249 || rd_data > 16'd251) begin miscompares++; $display("[TB] FAIL avg_second got %0d want 250+-1", rd_data); end
      quiesce();
   endtask
`endif

   initial begin
      $display("[TB] ultrasonic_scan_scheduler directed test start");
      test_reset();
      test_single_sensor();
      test_round_robin();
      test_no_echo();
      test_echo_timeout();
      test_mask_clear();
      test_reset_mid_trig();
`ifdef ULTRASONIC_AVG_EN
      test_average();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
